// File: rtl/hilo_div_pkg.sv
// Shared definitions for the HI/LO iterative divider: state encoding and default width.
package hilo_div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    ON   = 2'd2,
    END  = 2'd3
  } div_state_t;

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it is non-negative.
module hilo_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction; the extra top bit of diff is the borrow (negative result).
  always_comb begin
    shifted  = {rem, in_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    // Either branch is below the divisor, so it always fits in WIDTH bits.
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/hilo_div.sv
// Iterative MIPS-style DIV/DIVU unit producing LO (quotient) and HI (remainder).
// One quotient bit per cycle on operand magnitudes; signs are applied on the way out.
module hilo_div
  import hilo_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] opdata1,
  input  logic [WIDTH-1:0] opdata2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t state_reg, state_next;

  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] rem_reg;   // partial remainder
  logic [WIDTH-1:0] dq_reg;    // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] dvs_reg;   // divisor magnitude
  logic             sdiv_reg;
  logic             s1_reg;
  logic             s2_reg;
  logic             zero_reg;

  logic             busy_reg;
  logic             done_reg;
  logic             div_zero_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;

  logic             accept;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] rem_step;
  logic             q_bit;

  hilo_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_step_src()),
    .in_bit   (dq_reg[WIDTH-1]),
    .divisor  (dvs_reg),
    .rem_next (rem_step),
    .q_bit    (q_bit)
  );

  function automatic logic [WIDTH-1:0] rem_step_src();
    return rem_reg;
  endfunction

  // Operand magnitudes at capture and sign correction of the finished result.
  always_comb begin
    accept = (state_reg == IDLE) && start && !annul;
    mag1   = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    mag2   = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    // Most-negative / -1 falls out naturally: magnitude quotient wraps to itself.
    q_fix  = (sdiv_reg && (s1_reg ^ s2_reg)) ? -dq_reg : dq_reg;
    r_fix  = (sdiv_reg && s1_reg) ? -rem_reg : rem_reg;
  end

  // Next-state logic; annul aborts any in-flight operation.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (opdata2 == '0) ? ZERO : ON;
      ZERO: state_next = annul ? IDLE : END;
      ON: begin
        if (annul)                     state_next = IDLE;
        else if (cnt_reg == LAST_STEP) state_next = END;
      end
      END:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Operand capture and one restoring step per ON cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      rem_reg  <= '0;
      dq_reg   <= '0;
      dvs_reg  <= '0;
      sdiv_reg <= 1'b0;
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      zero_reg <= 1'b0;
    end else if (accept) begin
      cnt_reg  <= '0;
      rem_reg  <= '0;
      dq_reg   <= mag1;
      dvs_reg  <= mag2;
      sdiv_reg <= signed_div;
      s1_reg   <= signed_div & opdata1[WIDTH-1];
      s2_reg   <= signed_div & opdata2[WIDTH-1];
      zero_reg <= (opdata2 == '0);
    end else if (state_reg == ON && !annul) begin
      cnt_reg  <= cnt_reg + CW'(1);
      rem_reg  <= rem_step;
      dq_reg   <= {dq_reg[WIDTH-2:0], q_bit};
    end
  end

  // Registered status and HI/LO results, written only by a completed END.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      div_zero_reg  <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_reg == END) && !annul;
      if (state_reg == END && !annul) begin
        div_zero_reg  <= zero_reg;
        quotient_reg  <= zero_reg ? '0 : q_fix;
        remainder_reg <= zero_reg ? '0 : r_fix;
      end
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: doc/hilo_div.md
HILO_DIV -- requirements
Module: hilo_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal 8..64, even).
REQ-002 SHALL have ports clk input 1 (system clock) and rst input 1 (reset); there is one clock, and reset is asynchronous and active-low.
REQ-003 SHALL have port start input 1: request to begin a divide, sampled on the rising clk edge.
REQ-004 SHALL have port signed_div input 1: 1 = DIV (signed), 0 = DIVU (unsigned), sampled with start.
REQ-005 SHALL have port annul input 1: pipeline flush that aborts the operation in progress.
REQ-006 SHALL have ports opdata1 input WIDTH (dividend) and opdata2 input WIDTH (divisor), both sampled with start.
REQ-007 SHALL have port busy output 1: an operation is in progress, driven as the pipeline stall request.
REQ-008 SHALL have port done output 1: a one-cycle pulse marking quotient/remainder valid, driven as the HI/LO write enable.
REQ-009 SHALL have ports quotient output WIDTH (LO) and remainder output WIDTH (HI).
REQ-010 SHALL have port div_zero output 1: the last completed operation had a zero divisor.

Function
REQ-011 SHALL implement a four-state FSM with states IDLE, ZERO, ON and END.
REQ-012 IDLE transitions: start=1 and annul=0 goes to ZERO when opdata2==0; it goes to ON otherwise.
REQ-013 Operand capture: the FSM SHALL capture the operands and signed_div on the same edge it leaves IDLE.
REQ-014 Signed operands: when signed_div=1, the FSM SHALL capture the absolute values of the operands and record the sign of each operand.
REQ-015 ON state: each cycle SHALL perform one restoring step (shift the partial remainder left by 1, trial-subtract the divisor, set the quotient bit when the result is non-negative).
REQ-016 ON length: the FSM SHALL stay in ON for exactly WIDTH cycles, counted by a log2(WIDTH)+1-bit counter, then go to END.
REQ-017 ZERO state: SHALL last one cycle, then go to END with the result forced to quotient=0, remainder=0, div_zero=1.
REQ-018 END state: SHALL last one cycle, assert done=1, update quotient, remainder and div_zero, then return to IDLE.
REQ-019 Sign correction: in END with signed_div=1, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-020 Overflow case: signed most-negative / -1 SHALL give quotient = most-negative value (two's-complement wrap) and remainder=0, with no flag raised.
REQ-021 Latency: done SHALL assert WIDTH+1 cycles after the start-sampling edge for a nonzero divisor, and 2 cycles after it for a zero divisor.
REQ-022 busy SHALL be 1 in ZERO, ON and END, and 0 in IDLE.
REQ-023 busy SHALL be registered, rising on the edge after start is accepted.
REQ-024 start SHALL be ignored while busy=1; there is no queuing.
REQ-025 annul=1 in ZERO, ON or END SHALL return the FSM to IDLE on the next edge with done=0.
REQ-026 An annulled operation SHALL leave quotient, remainder and div_zero unchanged.
REQ-027 annul=1 together with start=1 in IDLE: SHALL stay in IDLE and ignore start.
REQ-028 quotient, remainder and div_zero SHALL hold their values until the next END; done SHALL be 0 at all other times.
REQ-029 A new start may be accepted in the cycle immediately after END, giving back-to-back operation.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, and clear the counter and all internal registers.
REQ-031 A reset during ZERO, ON or END SHALL discard the operation with no done pulse.
REQ-032 After rst is released, the first accepted start SHALL behave identically to any other start.

Structure
REQ-033 Shared package hilo_div_pkg SHALL hold the state-encoding typedef (IDLE/ZERO/ON/END) and the constant DIV_WIDTH_DEFAULT=32.
REQ-034 SHALL instantiate one sub-module, hilo_div_step: a combinational, WIDTH-parametrised trial subtractor returning the next partial remainder and the quotient bit.
REQ-035 Sign handling, counter and output registers SHALL remain in hilo_div; there is no other hierarchy.

Verification (WIDTH=32)
REQ-036 Unsigned divide: unsigned 100/7 -> done at cycle 33 after start, quotient=14, remainder=2, div_zero=0.
REQ-037 Signed divide: signed -7/2 (0xFFFFFFF9/0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-038 Zero divisor: 5/0 -> done at cycle 2, quotient=0, remainder=0, div_zero=1; the next valid divide clears div_zero.
REQ-039 Signed overflow: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-040 Annul and busy rules: annul at the 10th ON cycle -> busy=0 next cycle, no done, previous results retained; start pulsed while busy -> ignored, single done.
REQ-041 Reset mid-operation: rst=0 asserted mid-ON (asynchronous, between edges) -> all outputs 0 immediately; after release, 100/7 completes normally.
